// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED driver control blocks.
// Contents: FSM state encodings, default LED width, mode-index width and
//           a one-hot enable helper sized for the largest supported mode count.
package led_ctrl_pkg;

    localparam logic [0:0]  ST_BLANK  = 1'b0;
    localparam logic [0:0]  ST_RUN    = 1'b1;

    localparam int unsigned LED_W_DEF = 18;
    localparam int unsigned MAX_MODES = 8;
    localparam int unsigned IDX_W     = 3;

    // Enable vector for engine idx; callers truncate to their mode count.
    function automatic logic [MAX_MODES-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = MAX_MODES'(1) << idx;
    endfunction

endpackage

// File: rtl/led_btn_edge.sv
// Rising-edge detector for a debounced panel input.
// Ports:
//   clk    in  1  clock, all logic on posedge
//   reset  in  1  synchronous, active-high
//   level  in  1  debounced input level
//   rise_c out 1  combinational pulse: level high now, low on previous cycle
// A held level produces a single pulse.
module led_btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise_c
);

    logic level_q;

    // Previous-cycle copy of the input level.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise_c = level & ~level_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Scheduler for the LED driver mode engines.
// Grants one engine at a time its enable, muxes its pattern onto LEDr and
// inserts a blanking interval (all enables low) between modes.
// Optional feature macro: LED_MODE_AUTO_EN -- also advance after
// LOOPS_PER_MODE completed pattern cycles of the active engine.
// Ports:
//   PULSE     in   1                 clock, all logic on posedge
//   RESET     in   1                 synchronous, active-high
//   BTN_NEXT  in   1                 debounced button; rising edge requests next mode
//   MODE_DONE in   NUM_MODES         per-engine pattern-cycle-complete pulses
//   LED_IN    in   NUM_MODES*LED_W   engine patterns, engine i at [i*LED_W +: LED_W]
//   MODE_ON   out  NUM_MODES         one-hot engine enable, zero while blanking
//   LEDr      out  LED_W             registered LED drive
//   mode_idx  out  3                 current/next engine index
//   busy      out  1                 high while blanking
module led_mode_sequencer
    import led_ctrl_pkg::*;
#(
    parameter int unsigned NUM_MODES      = 4,
    parameter int unsigned LED_W          = LED_W_DEF,
    parameter int unsigned BLANK_CYCLES   = 4,
    parameter int unsigned LOOPS_PER_MODE = 3
) (
    input  logic                       PULSE,
    input  logic                       RESET,
    input  logic                       BTN_NEXT,
    input  logic [NUM_MODES-1:0]       MODE_DONE,
    input  logic [NUM_MODES*LED_W-1:0] LED_IN,
    output logic [NUM_MODES-1:0]       MODE_ON,
    output logic [LED_W-1:0]           LEDr,
    output logic [IDX_W-1:0]           mode_idx,
    output logic                       busy
);

    localparam int unsigned BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [BCW-1:0]       blank_cnt;
    logic [BCW-1:0]       blank_cnt_nxt;
    logic [IDX_W-1:0]     idx_nxt;
    logic [IDX_W-1:0]     idx_inc;
    logic [NUM_MODES-1:0] on_nxt;
    logic [LED_W-1:0]     led_nxt;
    logic [LED_W-1:0]     led_sel;
    logic                 busy_nxt;
    logic                 btn_rise_c;
    logic                 auto_adv;
    logic                 adv;

    led_btn_edge u_btn_edge (
        .clk    (PULSE),
        .reset  (RESET),
        .level  (BTN_NEXT),
        .rise_c (btn_rise_c)
    );

    // Pattern of the engine selected by mode_idx.
    always_comb begin
        led_sel = '0;
        for (int i = 0; i < int'(NUM_MODES); i++) begin
            if (mode_idx == IDX_W'(i)) begin
                led_sel = LED_IN[i*LED_W +: LED_W];
            end
        end
    end

    assign idx_inc = (mode_idx == IDX_W'(NUM_MODES - 1)) ? '0 : mode_idx + IDX_W'(1);

    // Button and auto-advance merge into one event, so a coincidence is a single step.
    assign adv = (state == ST_RUN) && (btn_rise_c || auto_adv);

`ifdef LED_MODE_AUTO_EN
    localparam int unsigned LCW = $clog2(LOOPS_PER_MODE + 1);

    logic [LCW-1:0] loop_cnt;
    logic [LCW-1:0] loop_cnt_nxt;
    logic           done_sel;

    // Only the active engine's done pulse counts.
    always_comb begin
        done_sel = 1'b0;
        for (int i = 0; i < int'(NUM_MODES); i++) begin
            if (mode_idx == IDX_W'(i)) begin
                done_sel = MODE_DONE[i];
            end
        end
    end

    // The pulse that completes the last loop triggers the advance on the same edge.
    assign auto_adv = done_sel && (loop_cnt == LCW'(LOOPS_PER_MODE - 1));

    always_comb begin
        loop_cnt_nxt = loop_cnt;
        if (state == ST_RUN) begin
            if (adv) begin
                loop_cnt_nxt = '0;
            end else if (done_sel) begin
                loop_cnt_nxt = loop_cnt + LCW'(1);
            end
        end
    end

    always_ff @(posedge PULSE) begin
        if (RESET) begin
            loop_cnt <= '0;
        end else begin
            loop_cnt <= loop_cnt_nxt;
        end
    end
`else
    logic unused_done;

    assign auto_adv    = 1'b0;
    assign unused_done = (^MODE_DONE) ^ (LOOPS_PER_MODE == 0);
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt     = state;
        blank_cnt_nxt = blank_cnt;
        idx_nxt       = mode_idx;
        on_nxt        = MODE_ON;
        led_nxt       = LEDr;
        busy_nxt      = busy;
        case (state)
            ST_BLANK: begin
                on_nxt   = '0;
                led_nxt  = '0;
                busy_nxt = 1'b1;
                if (blank_cnt == BCW'(BLANK_CYCLES - 1)) begin
                    state_nxt     = ST_RUN;
                    blank_cnt_nxt = '0;
                    on_nxt        = NUM_MODES'(onehot(mode_idx));
                    busy_nxt      = 1'b0;
                end else begin
                    blank_cnt_nxt = blank_cnt + BCW'(1);
                end
            end
            default: begin
                on_nxt   = NUM_MODES'(onehot(mode_idx));
                led_nxt  = led_sel;
                busy_nxt = 1'b0;
                if (adv) begin
                    state_nxt = ST_BLANK;
                    idx_nxt   = idx_inc;
                    on_nxt    = '0;
                    busy_nxt  = 1'b1;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge PULSE) begin
        if (RESET) begin
            state     <= ST_BLANK;
            blank_cnt <= '0;
            mode_idx  <= '0;
            MODE_ON   <= '0;
            LEDr      <= '0;
            busy      <= 1'b1;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_cnt_nxt;
            mode_idx  <= idx_nxt;
            MODE_ON   <= on_nxt;
            LEDr      <= led_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer with a cycle-level reference model.
module tb_led_mode_sequencer;

    localparam int NM    = 4;
    localparam int LW    = 18;
    localparam int BLANK = 4;
    localparam int LOOPS = 3;
    localparam int LEDS  = NM * LW;

    logic            PULSE = 1'b0;
    logic            RESET;
    logic            BTN_NEXT;
    logic [NM-1:0]   MODE_DONE;
    logic [LEDS-1:0] LED_IN;
    logic [NM-1:0]   MODE_ON;
    logic [LW-1:0]   LEDr;
    logic [2:0]      mode_idx;
    logic            busy;

    int checks = 0;
    int errors = 0;

    led_mode_sequencer #(
        .NUM_MODES      (NM),
        .LED_W          (LW),
        .BLANK_CYCLES   (BLANK),
        .LOOPS_PER_MODE (LOOPS)
    ) dut (
        .PULSE     (PULSE),
        .RESET     (RESET),
        .BTN_NEXT  (BTN_NEXT),
        .MODE_DONE (MODE_DONE),
        .LED_IN    (LED_IN),
        .MODE_ON   (MODE_ON),
        .LEDr      (LEDr),
        .mode_idx  (mode_idx),
        .busy      (busy)
    );

    always #5 PULSE = ~PULSE;

    // Reference model: blanking countdown, current mode, loop tally, last button level.
    logic [NM-1:0] exp_on   = '0;
    logic [LW-1:0] exp_led  = '0;
    logic [2:0]    exp_idx  = '0;
    logic          exp_busy = 1'b1;
    int            m_idx    = 0;
    int            m_left   = BLANK;
    int            m_loops  = 0;
    bit            m_blanking = 1'b1;
    bit            m_prev   = 1'b0;

    function automatic logic [LW-1:0] slice_of(input logic [LEDS-1:0] v, input int i);
        return v[i*LW +: LW];
    endfunction

    always @(posedge PULSE) begin
        bit press;
        bit go;
        if (RESET) begin
            m_blanking = 1'b1;
            m_left     = BLANK;
            m_idx      = 0;
            m_loops    = 0;
            m_prev     = 1'b0;
            exp_on     = '0;
            exp_led    = '0;
            exp_busy   = 1'b1;
        end else begin
            press  = BTN_NEXT && !m_prev;
            m_prev = BTN_NEXT;
            if (m_blanking) begin
                exp_led = '0;
                m_left  = m_left - 1;
                if (m_left == 0) begin
                    m_blanking = 1'b0;
                    exp_on     = NM'(1) << m_idx;
                    exp_busy   = 1'b0;
                end
            end else begin
                exp_led = slice_of(LED_IN, m_idx);
                go      = press;
`ifdef LED_MODE_AUTO_EN
                if (MODE_DONE[m_idx]) m_loops = m_loops + 1;
                if (m_loops == LOOPS) go = 1'b1;
`endif
                if (go) begin
                    m_blanking = 1'b1;
                    m_left     = BLANK;
                    m_idx      = (m_idx + 1) % NM;
                    m_loops    = 0;
                    exp_on     = '0;
                    exp_busy   = 1'b1;
                end
            end
        end
        exp_idx = 3'(m_idx);
    end

    task automatic rand_led();
        LED_IN = LEDS'({$urandom(), $urandom(), $urandom()});
    endtask

    task automatic do_reset();
        RESET = 1'b1; BTN_NEXT = 1'b0; MODE_DONE = '0;
        @(negedge PULSE);
        @(negedge PULSE);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        logic [LW-1:0] first;
        first = '0;
        RESET = 1'b1; BTN_NEXT = 1'b0; MODE_DONE = '0; rand_led();
        @(negedge PULSE);
        @(negedge PULSE);
        checks++;
        if ({MODE_ON, LEDr, mode_idx, busy} !== {4'b0000, 18'd0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: on=%b led=%h idx=%0d busy=%b want on=0000 led=0 idx=0 busy=1",
                     MODE_ON, LEDr, mode_idx, busy);
        end
        RESET = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge PULSE);
            checks++;
            if ({MODE_ON, LEDr, mode_idx, busy} !== {exp_on, exp_led, exp_idx, exp_busy}) begin
                errors++;
                $display("FAIL reset_model c=%0d: on=%b led=%h idx=%0d busy=%b want on=%b led=%h idx=%0d busy=%b",
                         c, MODE_ON, LEDr, mode_idx, busy, exp_on, exp_led, exp_idx, exp_busy);
            end
            checks++;
            if (MODE_ON !== ((c >= 4) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL reset_blank c=%0d: on=%b want %b", c, MODE_ON, (c >= 4) ? 4'b0001 : 4'b0000);
            end
            if (c == 5) begin
                checks++;
                if (LEDr !== first) begin
                    errors++;
                    $display("FAIL reset_first_led: led=%h want %h", LEDr, first);
                end
            end
            rand_led();
            first = LED_IN[LW-1:0];
        end
    endtask

    task automatic test_hold();
        int changes;
        int zeros;
        logic [2:0] prev;
        changes = 0; zeros = 0; prev = mode_idx;
        BTN_NEXT = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge PULSE);
            checks++;
            if ({MODE_ON, LEDr, mode_idx, busy} !== {exp_on, exp_led, exp_idx, exp_busy}) begin
                errors++;
                $display("FAIL hold_model c=%0d: on=%b led=%h idx=%0d busy=%b want on=%b led=%h idx=%0d busy=%b",
                         c, MODE_ON, LEDr, mode_idx, busy, exp_on, exp_led, exp_idx, exp_busy);
            end
            if (mode_idx !== prev) changes++;
            if (MODE_ON == '0) zeros++;
            prev = mode_idx;
            rand_led();
        end
        BTN_NEXT = 1'b0;
        checks++;
        if (changes != 1 || zeros != BLANK) begin
            errors++;
            $display("FAIL hold_single: changes=%0d zero_cycles=%0d want 1 and %0d", changes, zeros, BLANK);
        end
        checks++;
        if ({MODE_ON, mode_idx} !== {4'b0010, 3'd1}) begin
            errors++;
            $display("FAIL hold_final: on=%b idx=%0d want on=0010 idx=1", MODE_ON, mode_idx);
        end
    endtask

    task automatic test_presses();
        int          want_idx [4] = '{1, 2, 3, 0};
        logic [3:0]  want_on  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        repeat (6) @(negedge PULSE);
        for (int p = 0; p < 4; p++) begin
            BTN_NEXT = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge PULSE);
                checks++;
                if ({MODE_ON, LEDr, mode_idx, busy} !== {exp_on, exp_led, exp_idx, exp_busy}) begin
                    errors++;
                    $display("FAIL press_model p=%0d c=%0d: on=%b led=%h idx=%0d busy=%b want on=%b led=%h idx=%0d busy=%b",
                             p, c, MODE_ON, LEDr, mode_idx, busy, exp_on, exp_led, exp_idx, exp_busy);
                end
                BTN_NEXT = 1'b0;
                rand_led();
            end
            checks++;
            if ({MODE_ON, mode_idx} !== {want_on[p], 3'(want_idx[p])}) begin
                errors++;
                $display("FAIL press_seq p=%0d: on=%b idx=%0d want on=%b idx=%0d",
                         p, MODE_ON, mode_idx, want_on[p], want_idx[p]);
            end
        end
    endtask

    task automatic test_blank_press();
        int changes;
        logic [2:0] prev;
        changes = 0; prev = mode_idx;
        for (int c = 0; c < 14; c++) begin
            BTN_NEXT = (c == 0 || c == 2);
            @(negedge PULSE);
            checks++;
            if ({MODE_ON, LEDr, mode_idx, busy} !== {exp_on, exp_led, exp_idx, exp_busy}) begin
                errors++;
                $display("FAIL blank_press_model c=%0d: on=%b led=%h idx=%0d busy=%b want on=%b led=%h idx=%0d busy=%b",
                         c, MODE_ON, LEDr, mode_idx, busy, exp_on, exp_led, exp_idx, exp_busy);
            end
            if (mode_idx !== prev) changes++;
            prev = mode_idx;
            rand_led();
        end
        BTN_NEXT = 1'b0;
        checks++;
        if (changes != 1 || mode_idx !== 3'd1 || MODE_ON !== 4'b0010) begin
            errors++;
            $display("FAIL blank_press_ignored: changes=%0d idx=%0d on=%b want 1, 1, 0010",
                     changes, mode_idx, MODE_ON);
        end
    endtask

`ifdef LED_MODE_AUTO_EN
    task automatic test_auto();
        do_reset();
        repeat (6) @(negedge PULSE);
        BTN_NEXT = 1'b1;
        @(negedge PULSE);
        BTN_NEXT = 1'b0;
        repeat (8) @(negedge PULSE);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 3; c++) begin
                MODE_DONE = (c == 1) ? 4'b0100 : 4'b0000;
                if (c == 2) MODE_DONE = 4'b0110;
                BTN_NEXT = (k == 2 && c == 2);
                @(negedge PULSE);
                checks++;
                if ({MODE_ON, LEDr, mode_idx, busy} !== {exp_on, exp_led, exp_idx, exp_busy}) begin
                    errors++;
                    $display("FAIL auto_model k=%0d c=%0d: on=%b led=%h idx=%0d busy=%b want on=%b led=%h idx=%0d busy=%b",
                             k, c, MODE_ON, LEDr, mode_idx, busy, exp_on, exp_led, exp_idx, exp_busy);
                end
                rand_led();
            end
            checks++;
            if (mode_idx !== ((k == 2) ? 3'd2 : 3'd1)) begin
                errors++;
                $display("FAIL auto_count k=%0d: idx=%0d want %0d", k, mode_idx, (k == 2) ? 2 : 1);
            end
        end
        BTN_NEXT = 1'b0; MODE_DONE = '0;
        repeat (10) @(negedge PULSE);
        checks++;
        if ({MODE_ON, mode_idx} !== {4'b0100, 3'd2}) begin
            errors++;
            $display("FAIL auto_single: on=%b idx=%0d want on=0100 idx=2", MODE_ON, mode_idx);
        end
    endtask
`endif

    task automatic test_reset_mid_blank();
        int first_on;
        do_reset();
        repeat (6) @(negedge PULSE);
        for (int p = 0; p < 2; p++) begin
            BTN_NEXT = 1'b1;
            @(negedge PULSE);
            BTN_NEXT = 1'b0;
            repeat ((p == 0) ? 8 : 2) @(negedge PULSE);
        end
        checks++;
        if ({mode_idx, busy} !== {3'd2, 1'b1}) begin
            errors++;
            $display("FAIL midblank_setup: idx=%0d busy=%b want idx=2 busy=1", mode_idx, busy);
        end
        RESET = 1'b1;
        @(negedge PULSE);
        RESET = 1'b0;
        checks++;
        if ({MODE_ON, LEDr, mode_idx, busy} !== {4'b0000, 18'd0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL midblank_reset: on=%b led=%h idx=%0d busy=%b want on=0000 led=0 idx=0 busy=1",
                     MODE_ON, LEDr, mode_idx, busy);
        end
        first_on = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge PULSE);
            checks++;
            if ({MODE_ON, LEDr, mode_idx, busy} !== {exp_on, exp_led, exp_idx, exp_busy}) begin
                errors++;
                $display("FAIL midblank_model c=%0d: on=%b led=%h idx=%0d busy=%b want on=%b led=%h idx=%0d busy=%b",
                         c, MODE_ON, LEDr, mode_idx, busy, exp_on, exp_led, exp_idx, exp_busy);
            end
            if (first_on == 0 && MODE_ON != '0) first_on = c;
            rand_led();
        end
        checks++;
        if (first_on != BLANK) begin
            errors++;
            $display("FAIL midblank_full_blank: enable after %0d cycles want %0d", first_on, BLANK);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge PULSE);
            checks++;
            if ({MODE_ON, LEDr, mode_idx, busy} !== {exp_on, exp_led, exp_idx, exp_busy}) begin
                errors++;
                $display("FAIL random c=%0d: on=%b led=%h idx=%0d busy=%b want on=%b led=%h idx=%0d busy=%b",
                         c, MODE_ON, LEDr, mode_idx, busy, exp_on, exp_led, exp_idx, exp_busy);
            end
            if ($urandom_range(0, 5) == 0) BTN_NEXT = ~BTN_NEXT;
            for (int b = 0; b < NM; b++) MODE_DONE[b] = ($urandom_range(0, 4) == 0);
            RESET = ($urandom_range(0, 149) == 0);
            rand_led();
        end
        RESET = 1'b0; BTN_NEXT = 1'b0; MODE_DONE = '0;
    endtask

    initial begin
        test_reset();
        test_hold();
        test_presses();
        test_blank_press();
`ifdef LED_MODE_AUTO_EN
        test_auto();
`endif
        test_reset_mid_blank();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
